dorodon_rom_loader: RTL and testbench

- Sequences the HPS ioctl download stream into the Dorodon core's ROM regions: CPU program, character graphics, sprite graphics and colour PROMs.
- Decodes the linear download address into a per-region write strobe and local address, and checks that the stream is sequential and complete.
- Owns the core reset: the core is held in reset until a verified image is loaded, plus a settle period, and whenever a user reset is requested.
- Sits between hps_io and the ladybug core in the top-level emu module.

---
 rtl/dorodon_rom_pkg.sv | 33 +++
 rtl/dorodon_rom_decode.sv | 40 ++++
 rtl/dorodon_rom_loader.sv | 150 +++++++++++++++
 tb/tb_dorodon_rom_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dorodon_rom_pkg.sv
// Shared definitions for the Dorodon ROM loader: download region map,
// region indices and loader FSM states.
package dorodon_rom_pkg;

  // Region map of the linear download image (byte addresses).
  localparam logic [15:0] CPU_BASE  = 16'h0000;
  localparam logic [15:0] CPU_SIZE  = 16'h6000;
  localparam logic [15:0] CHR_BASE  = 16'h6000;
  localparam logic [15:0] CHR_SIZE  = 16'h1000;
  localparam logic [15:0] SPR_BASE  = 16'h7000;
  localparam logic [15:0] SPR_SIZE  = 16'h1000;
  localparam logic [15:0] PROM_BASE = 16'h8000;
  localparam logic [15:0] PROM_SIZE = 16'h0080;
  localparam logic [15:0] TOTAL_LEN = 16'h8080;

  // Bit position of each region in the one-hot write strobe.
  typedef enum logic [1:0] {
    REG_CPU  = 2'd0,
    REG_CHR  = 2'd1,
    REG_SPR  = 2'd2,
    REG_PROM = 2'd3
  } region_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_HOLD,
    ST_RUN,
    ST_FAIL
  } state_e;

endpackage

// File: rtl/dorodon_rom_decode.sv
// Combinational decode of a download byte address into a one-hot region
// strobe and a region-local byte address.
module dorodon_rom_decode
  import dorodon_rom_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [3:0]        o_region_oh,
  output logic [14:0]       o_local_addr,
  output logic              o_in_map
);

  // Region lookup; every region fits in 15 bits, so the local offset is
  // computed on the low 15 bits only.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_region_oh  = '0;
    o_local_addr = '0;
    o_in_map     = 1'b0;
    if (i_addr < CPU_BASE + CPU_SIZE) begin
      o_region_oh[REG_CPU] = 1'b1;
      o_local_addr         = i_addr[14:0] - CPU_BASE[14:0];
      o_in_map             = 1'b1;
    end else if (i_addr < CHR_BASE + CHR_SIZE) begin
      o_region_oh[REG_CHR] = 1'b1;
      o_local_addr         = i_addr[14:0] - CHR_BASE[14:0];
      o_in_map             = 1'b1;
    end else if (i_addr < SPR_BASE + SPR_SIZE) begin
      o_region_oh[REG_SPR] = 1'b1;
      o_local_addr         = i_addr[14:0] - SPR_BASE[14:0];
      o_in_map             = 1'b1;
    end else if (i_addr < PROM_BASE + PROM_SIZE) begin
      o_region_oh[REG_PROM] = 1'b1;
      o_local_addr          = i_addr[14:0] - PROM_BASE[14:0];
      o_in_map              = 1'b1;
    end
  end

endmodule

// File: rtl/dorodon_rom_loader.sv
// Routes the hps_io ioctl download into the Dorodon ROM regions, verifies
// the stream is sequential and complete, and owns the ladybug core reset.
module dorodon_rom_loader
  import dorodon_rom_pkg::*;
#(
  parameter int HOLD_CYCLES = 1024,
  parameter int ADDR_W      = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        user_reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [3:0]  rom_wr,
  output logic [14:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_error
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  state_e           r_state;
  state_e           w_state_next;
  logic             r_dl_prev;
  logic [15:0]      r_exp;
  logic             r_seq_err;
  logic             r_ovf_err;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [3:0]       r_rom_wr;
  logic [14:0]      r_rom_addr;
  logic [7:0]       r_rom_data;
  logic             r_core_reset;
  logic             r_load_done;
  logic             r_load_error;

  logic             w_dl_rise;
  logic             w_dl_fall;
  logic             w_addr_ovf;
  logic             w_addr_seq;
  logic             w_check_ok;
  logic             w_enter_load;
  logic             w_load_wr;
  logic [3:0]       w_region_oh;
  logic [14:0]      w_local_addr;
  logic             w_in_map;

  dorodon_rom_decode #(
    .ADDR_W(ADDR_W)
  ) u_decode (
    .i_addr      (ioctl_addr[ADDR_W-1:0]),
    .o_region_oh (w_region_oh),
    .o_local_addr(w_local_addr),
    .o_in_map    (w_in_map)
  );

  assign w_dl_rise    = ioctl_download & ~r_dl_prev;
  assign w_dl_fall    = ~ioctl_download & r_dl_prev;
  // The full 25-bit address is compared so high aliases never reach a ROM.
  assign w_addr_ovf   = ioctl_addr >= {9'd0, TOTAL_LEN};
  assign w_addr_seq   = ioctl_addr == {9'd0, r_exp};
  assign w_check_ok   = (r_exp == TOTAL_LEN) && !r_seq_err && !r_ovf_err;
  assign w_enter_load = (w_state_next == ST_LOAD) && (r_state != ST_LOAD);
  assign w_load_wr    = (r_state == ST_LOAD) && ioctl_wr;

  // State register.
  always_ff @(posedge clk_sys) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_dl_rise) w_state_next = ST_LOAD;
      ST_LOAD:  if (w_dl_fall) w_state_next = ST_CHECK;
      ST_CHECK: w_state_next = w_check_ok ? ST_HOLD : ST_FAIL;
      ST_HOLD:  if (r_hold_cnt == '0) w_state_next = ST_RUN;
      ST_RUN:   if (w_dl_rise) w_state_next = ST_LOAD;
      ST_FAIL:  if (w_dl_rise) w_state_next = ST_LOAD;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Write path, stream verification, hold counter and status outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_dl_prev    <= 1'b0;
      r_exp        <= '0;
      r_seq_err    <= 1'b0;
      r_ovf_err    <= 1'b0;
      r_hold_cnt   <= '0;
      r_rom_wr     <= '0;
      r_rom_addr   <= '0;
      r_rom_data   <= '0;
      r_core_reset <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_dl_prev <= ioctl_download;
      r_rom_wr  <= '0;
      // Core runs only in RUN; the user reset is passed through there and
      // is harmless elsewhere because the core is already held.
      r_core_reset <= (w_state_next != ST_RUN) || user_reset;

      if (w_enter_load) begin
        r_exp        <= '0;
        r_seq_err    <= 1'b0;
        r_ovf_err    <= 1'b0;
        r_load_done  <= 1'b0;
        r_load_error <= 1'b0;
      end else if (w_load_wr) begin
        if (w_addr_ovf) begin
          r_ovf_err <= 1'b1;
        end else begin
          // Out-of-order bytes are still written; the image is rejected later.
          if (w_in_map) begin
            r_rom_wr   <= w_region_oh;
            r_rom_addr <= w_local_addr;
            r_rom_data <= ioctl_dout;
          end
          if (w_addr_seq) r_exp <= r_exp + 16'd1;
          else            r_seq_err <= 1'b1;
        end
      end

      if (r_state == ST_CHECK) begin
        r_load_done  <= w_check_ok;
        r_load_error <= !w_check_ok;
        r_hold_cnt   <= CNT_W'(HOLD_CYCLES - 1);
      end else if (r_state == ST_HOLD && r_hold_cnt != '0) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
      end
    end
  end

  assign rom_wr     = r_rom_wr;
  assign rom_addr   = r_rom_addr;
  assign rom_data   = r_rom_data;
  assign core_reset = r_core_reset;
  assign load_done  = r_load_done;
  assign load_error = r_load_error;

endmodule

// File: tb/tb_dorodon_rom_loader.sv
// Directed bench for dorodon_rom_loader: reset, aborted load, full image,
// hold timing, user reset, short, out-of-order and oversize downloads.
module tb_dorodon_rom_loader;

  localparam int HOLD = 1024;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        user_reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [3:0]  rom_wr;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic        core_reset;
  logic        load_done;
  logic        load_error;

  int total = 0;
  int bad   = 0;

  // Boundary points of the region map: address, strobe, local address.
  int unsigned bp_addr [8] = '{'h0000, 'h5FFF, 'h6000, 'h6FFF, 'h7000, 'h7FFF, 'h8000, 'h807F};
  logic [3:0]  bp_wr   [8] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
  int unsigned bp_loc  [8] = '{'h0000, 'h5FFF, 'h0000, 'h0FFF, 'h0000, 'h0FFF, 'h0000, 'h007F};
  int unsigned region_size [4] = '{'h6000, 'h1000, 'h1000, 'h0080};

  dorodon_rom_loader #(
    .HOLD_CYCLES(HOLD),
    .ADDR_W     (16)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .user_reset    (user_reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .rom_wr        (rom_wr),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .core_reset    (core_reset),
    .load_done     (load_done),
    .load_error    (load_error)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [7:0] pattern(input logic [24:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // One ioctl byte strobe; outputs for this byte are visible on return.
  task automatic wr_byte(input logic [24:0] a);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = pattern(a);
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr"},    32'(rom_wr),     32'h0);
    check({tag, "_addr"},  32'(rom_addr),   32'h0);
    check({tag, "_data"},  32'(rom_data),   32'h0);
    check({tag, "_crst"},  32'(core_reset), 32'h1);
    check({tag, "_done"},  32'(load_done),  32'h0);
    check({tag, "_err"},   32'(load_error), 32'h0);
  endtask

  initial begin
    int pulses [4];
    int low_seen;

    reset          = 1'b1;
    user_reset     = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    repeat (3) tick();
    check_reset_values("rst");
    reset = 1'b0;
    tick();
    check("idle_crst", 32'(core_reset), 32'h1);

    // Download aborted by reset at byte 0x3000.
    ioctl_download = 1'b1;
    tick();
    for (int a = 0; a < 'h3000; a++) wr_byte(25'(a));
    check("abort_pre_addr", 32'(rom_addr), 32'h2FFF);
    reset          = 1'b1;
    ioctl_download = 1'b0;
    wr_byte(25'h3000);
    check_reset_values("abort");
    reset = 1'b0;
    tick();
    check("abort_idle_crst", 32'(core_reset), 32'h1);

    // Writes outside a download window are ignored.
    wr_byte(25'h0000);
    check("idle_wr_ignored", 32'(rom_wr), 32'h0);

    // Full sequential image.
    for (int b = 0; b < 4; b++) pulses[b] = 0;
    ioctl_download = 1'b1;
    tick();
    for (int a = 0; a < 'h8080; a++) begin
      wr_byte(25'(a));
      for (int b = 0; b < 4; b++) if (rom_wr[b]) pulses[b]++;
      for (int k = 0; k < 8; k++) begin
        if (a == bp_addr[k]) begin
          check($sformatf("map_wr@%0h", a),   32'(rom_wr),   32'(bp_wr[k]));
          check($sformatf("map_addr@%0h", a), 32'(rom_addr), bp_loc[k]);
          check($sformatf("map_data@%0h", a), 32'(rom_data), 32'(pattern(25'(a))));
        end
      end
    end
    for (int b = 0; b < 4; b++) check($sformatf("pulses_r%0d", b), pulses[b], region_size[b]);
    ioctl_download = 1'b0;
    tick();
    check("full_done_early", 32'(load_done), 32'h0);
    tick();
    check("full_done",  32'(load_done),  32'h1);
    check("full_err",   32'(load_error), 32'h0);
    check("full_crst",  32'(core_reset), 32'h1);
    repeat (HOLD - 1) tick();
    check("hold_last_crst", 32'(core_reset), 32'h1);
    tick();
    check("run_crst", 32'(core_reset), 32'h0);

    // User reset in RUN: 3-cycle pulse, delayed by one cycle.
    user_reset = 1'b1;
    #1;
    check("ur_delay", 32'(core_reset), 32'h0);
    tick();
    check("ur_c1", 32'(core_reset), 32'h1);
    tick();
    check("ur_c2", 32'(core_reset), 32'h1);
    tick();
    user_reset = 1'b0;
    check("ur_c3", 32'(core_reset), 32'h1);
    tick();
    check("ur_release", 32'(core_reset), 32'h0);

    // New download from RUN, stopped short at 0x7FFF.
    ioctl_download = 1'b1;
    tick();
    check("reload_crst", 32'(core_reset), 32'h1);
    check("reload_done", 32'(load_done),  32'h0);
    for (int a = 0; a < 'h8000; a++) wr_byte(25'(a));
    ioctl_download = 1'b0;
    repeat (2) tick();
    check("short_err",  32'(load_error), 32'h1);
    check("short_done", 32'(load_done),  32'h0);
    low_seen = 0;
    repeat (5000) begin
      tick();
      if (!core_reset) low_seen++;
    end
    check("short_crst_held", low_seen, 0);

    // Out-of-order byte: still written, image rejected.
    ioctl_download = 1'b1;
    tick();
    check("ooo_err_cleared", 32'(load_error), 32'h0);
    for (int a = 0; a < 5; a++) wr_byte(25'(a));
    wr_byte(25'h0010);
    check("ooo_wr",   32'(rom_wr),   32'h1);
    check("ooo_addr", 32'(rom_addr), 32'h0010);
    check("ooo_data", 32'(rom_data), 32'(pattern(25'h0010)));
    ioctl_download = 1'b0;
    repeat (2) tick();
    check("ooo_err",  32'(load_error), 32'h1);
    check("ooo_done", 32'(load_done),  32'h0);
    check("ooo_crst", 32'(core_reset), 32'h1);

    // Oversize bytes, including a high alias of address 0: never written.
    ioctl_download = 1'b1;
    tick();
    wr_byte(25'h8080);
    check("ovf_wr", 32'(rom_wr), 32'h0);
    wr_byte(25'h10000);
    check("ovf_alias_wr", 32'(rom_wr), 32'h0);
    ioctl_download = 1'b0;
    repeat (2) tick();
    check("ovf_err",  32'(load_error), 32'h1);
    check("ovf_done", 32'(load_done),  32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
